// File: rtl/mvm_sc_array.sv
// mvm_sc_array -- stochastic-computing matrix-vector multiplier.
//
// Each of DIM lanes turns its probability numerator x_i into a bit stream by
// comparing a lane-specific rotation of a shared maximal-length LFSR against
// x_i, and counts the stream for w cycles into a signed accumulator. Unipolar
// mode counts ones; bipolar mode counts +1/-1. Over a full LFSR period
// (w = 2^NUM_BIT-1) every nonzero LFSR value is seen exactly once, so the
// result is exact.
//
// Optional feature macro: MVM_SAT_EN
//   defined   : accumulators saturate at the signed ACC_BIT limits
//   undefined : accumulators wrap modulo 2^ACC_BIT
//
// Parameters:
//   DIM       lanes
//   NUM_BIT   width of x, w and the LFSR (4..16)
//   ACC_BIT   signed accumulator width (>= NUM_BIT)
//   LFSR_SEED LFSR value loaded at start (0 is replaced by 1)
//
// Ports:
//   i_clk_mvm     clock
//   i_rst_n_mvm   asynchronous active-low reset
//   i_start_mvm   start request, sampled only in IDLE
//   i_bipolar_mvm 0 = unipolar, 1 = bipolar (latched at start)
//   i_x_mvm       per-lane unsigned probability numerators (latched at start)
//   i_w_mvm       stream length in cycles (latched at start)
//   o_busy_mvm    high while streaming
//   o_done_mvm    one-cycle pulse when results are final
//   o_wx_result   per-lane signed results, held until the next start

// Per-lane stream generator and accumulator.
//   i_clr  clear accumulator (start accepted)
//   i_en   apply one stream bit
//   i_rnd  lane's rotated LFSR value
//   o_acc  signed accumulator
module mvm_sc_lane #(
  parameter int NUM_BIT = 8,
  parameter int ACC_BIT = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic               i_bipolar,
  input  logic [NUM_BIT-1:0] i_x,
  input  logic [NUM_BIT-1:0] i_rnd,
  output logic [ACC_BIT-1:0] o_acc
);
  logic               w_bit;
  logic [ACC_BIT-1:0] w_next;
  logic [ACC_BIT-1:0] r_acc;

  // x = 0 never fires (LFSR is never 0); x = all-ones always fires.
  assign w_bit = (i_rnd <= i_x);

`ifdef MVM_SAT_EN
  logic [ACC_BIT:0] w_step;
  logic [ACC_BIT:0] w_sum;

  always_comb begin
    w_step = '0;
    if (w_bit)          w_step = {{ACC_BIT{1'b0}}, 1'b1};
    else if (i_bipolar) w_step = '1;
    // One guard bit is enough for a +/-1 step; a guard/sign disagreement
    // means the sum left the range, so clamp toward the guard's sign.
    w_sum = {r_acc[ACC_BIT-1], r_acc} + w_step;
    if (w_sum[ACC_BIT] != w_sum[ACC_BIT-1])
      w_next = {w_sum[ACC_BIT], {(ACC_BIT-1){~w_sum[ACC_BIT]}}};
    else
      w_next = w_sum[ACC_BIT-1:0];
  end
`else
  logic [ACC_BIT-1:0] w_step;

  always_comb begin
    w_step = '0;
    if (w_bit)          w_step = {{(ACC_BIT-1){1'b0}}, 1'b1};
    else if (i_bipolar) w_step = '1;
    w_next = r_acc + w_step;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= w_next;
  end

  assign o_acc = r_acc;
endmodule

module mvm_sc_array #(
  parameter int DIM       = 4,
  parameter int NUM_BIT   = 8,
  parameter int ACC_BIT   = NUM_BIT + 2,
  parameter int LFSR_SEED = 1
) (
  input  logic                          i_clk_mvm,
  input  logic                          i_rst_n_mvm,
  input  logic                          i_start_mvm,
  input  logic                          i_bipolar_mvm,
  input  logic [DIM-1:0][NUM_BIT-1:0]   i_x_mvm,
  input  logic [NUM_BIT-1:0]            i_w_mvm,
  output logic                          o_busy_mvm,
  output logic                          o_done_mvm,
  output logic [DIM-1:0][ACC_BIT-1:0]   o_wx_result
);
  // Feedback masks for maximal-length polynomials, bit (t-1) set for tap t.
  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      4:       tap_mask = 16'h000C; // x^4+x^3+1
      5:       tap_mask = 16'h0014; // x^5+x^3+1
      6:       tap_mask = 16'h0030; // x^6+x^5+1
      7:       tap_mask = 16'h0060; // x^7+x^6+1
      8:       tap_mask = 16'h00B8; // x^8+x^6+x^5+x^4+1
      9:       tap_mask = 16'h0110; // x^9+x^5+1
      10:      tap_mask = 16'h0240; // x^10+x^7+1
      11:      tap_mask = 16'h0500; // x^11+x^9+1
      12:      tap_mask = 16'h0829; // x^12+x^6+x^4+x+1
      13:      tap_mask = 16'h100D; // x^13+x^4+x^3+x+1
      14:      tap_mask = 16'h2015; // x^14+x^5+x^3+x+1
      15:      tap_mask = 16'h6000; // x^15+x^14+1
      16:      tap_mask = 16'hD008; // x^16+x^15+x^13+x^4+1
      default: tap_mask = 16'h00B8;
    endcase
  endfunction

  localparam logic [15:0]        TAPS_ALL = tap_mask(NUM_BIT);
  localparam logic [NUM_BIT-1:0] TAPS     = TAPS_ALL[NUM_BIT-1:0];
  localparam logic [NUM_BIT-1:0] SEED_RAW = NUM_BIT'(LFSR_SEED);
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [NUM_BIT-1:0] SEED     = (SEED_RAW == '0) ? NUM_BIT'(1) : SEED_RAW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_load;
  logic                        w_step;
  logic                        w_last;
  logic [DIM-1:0][NUM_BIT-1:0] r_x;
  logic [NUM_BIT-1:0]          r_w;
  logic                        r_bip;
  logic [NUM_BIT-1:0]          r_lfsr;
  logic [NUM_BIT-1:0]          r_cnt;

  // Counter holds the number of updates already applied; the update made
  // while it equals w-1 is the last one.
  assign w_last = (r_cnt == (r_w - NUM_BIT'(1)));

  always_ff @(posedge i_clk_mvm or negedge i_rst_n_mvm) begin
    if (!i_rst_n_mvm) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start_mvm) begin
          w_load      = 1'b1;
          w_state_nxt = (i_w_mvm == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_mvm or negedge i_rst_n_mvm) begin
    if (!i_rst_n_mvm) begin
      r_x    <= '0;
      r_w    <= '0;
      r_bip  <= 1'b0;
      r_lfsr <= SEED;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_x    <= i_x_mvm;
      r_w    <= i_w_mvm;
      r_bip  <= i_bipolar_mvm;
      r_lfsr <= SEED;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_lfsr <= {r_lfsr[NUM_BIT-2:0], ^(r_lfsr & TAPS)};
      r_cnt  <= r_cnt + NUM_BIT'(1);
    end
  end

  assign o_busy_mvm = (r_state == S_RUN);
  assign o_done_mvm = (r_state == S_DONE);

  // Each lane sees the LFSR rotated left by (lane mod NUM_BIT) so that lanes
  // get decorrelated streams while still covering the full period.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    localparam int ROT = gi % NUM_BIT;
    logic [NUM_BIT-1:0] w_rnd;

    if (ROT == 0) begin : g_norot
      assign w_rnd = r_lfsr;
    end else begin : g_rot
      assign w_rnd = {r_lfsr[NUM_BIT-1-ROT:0], r_lfsr[NUM_BIT-1:NUM_BIT-ROT]};
    end

    mvm_sc_lane #(
      .NUM_BIT (NUM_BIT),
      .ACC_BIT (ACC_BIT)
    ) u_lane (
      .i_clk     (i_clk_mvm),
      .i_rst_n   (i_rst_n_mvm),
      .i_clr     (w_load),
      .i_en      (w_step),
      .i_bipolar (r_bip),
      .i_x       (r_x[gi]),
      .i_rnd     (w_rnd),
      .o_acc     (o_wx_result[gi])
    );
  end
endmodule
